// File: rtl/score_tracker.sv
// Purpose  : BCD game score counter with auto-tick, bonus add, saturation and session high score.
// Latency  : all outputs registered or decoded from the state register; inputs act on the next edge.
// Backpress: none; start/pause/gameover are levels and bonus is a single-cycle pulse.
//
// Ports:
//   clk, reset         system clock; synchronous active-high reset
//   start              level; begins a new round from IDLE or OVER
//   pause              level; freezes scoring and the tick counter while high
//   gameover           level; ends the round (RUN or PAUSE -> OVER)
//   bonus              single-cycle pulse; +10 points while running
//   score_bcd          current score, DIGITS BCD digits, digit 0 in [3:0]
//   high_bcd           session high score
//   running / over     decoded RUN / OVER state
//   new_high           last finished round raised the high score
//
// Optional feature: define SCORE_TRACKER_HIGHSCORE_EN to build the high-score
// register, comparator and new_high flag; otherwise both outputs are tied to 0.

module score_tracker #(
   parameter int DIGITS   = 6,
   parameter int TICK_DIV = 25_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  gameover,
   input  logic                  bonus,
   output logic [4*DIGITS-1:0]   score_bcd,
   output logic [4*DIGITS-1:0]   high_bcd,
   output logic                  running,
   output logic                  over,
   output logic                  new_high
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         tick_cnt;
   logic                  new_round;   // entering RUN from IDLE or OVER
   logic                  score_en;    // RUN cycle that actually scores
   logic                  tick;
   logic [4*DIGITS-1:0]   sum_bcd;
   logic [4*DIGITS-1:0]   nines;
   logic                  sum_ovf;

   // ---------------------------------------------------------------
   // State machine
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      new_round = 1'b0;
      score_en  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
               new_round = 1'b1;
            end
         end
         S_RUN: begin
            // gameover wins over pause; a scoring event on the ending edge is dropped
            if (gameover)   state_nxt = S_OVER;
            else if (pause) state_nxt = S_PAUSE;
            else            score_en  = 1'b1;
         end
         S_PAUSE: begin
            if (gameover)    state_nxt = S_OVER;
            else if (!pause) state_nxt = S_RUN;
         end
         S_OVER: begin
            if (start) begin
               state_nxt = S_RUN;
               new_round = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign running = (state == S_RUN);
   assign over    = (state == S_OVER);

   // ---------------------------------------------------------------
   // Tick divider: only advances on scoring RUN cycles, so a pause
   // preserves the phase of the interrupted period.
   // ---------------------------------------------------------------
   assign tick = score_en && (tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (reset)          tick_cnt <= '0;
      else if (new_round) tick_cnt <= '0;
      else if (score_en)  tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
   end

   // ---------------------------------------------------------------
   // BCD adder: tick injects +1 at digit 0, bonus +1 at digit 1.
   // A carry out of the top digit (or a bonus with a single digit)
   // means the result no longer fits, so the score saturates.
   // ---------------------------------------------------------------
   always_comb begin
      logic       c;
      logic [4:0] dsum;
      sum_bcd = '0;
      nines   = '0;
      c       = 1'b0;
      dsum    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         dsum = {1'b0, score_bcd[4*i +: 4]} + {4'd0, c};
         if (i == 0) dsum = dsum + {4'd0, tick};
         if (i == 1) dsum = dsum + {4'd0, bonus};
         if (dsum > 5'd9) begin
            sum_bcd[4*i +: 4] = 4'(dsum - 5'd10);
            c = 1'b1;
         end else begin
            sum_bcd[4*i +: 4] = dsum[3:0];
            c = 1'b0;
         end
         nines[4*i +: 4] = 4'd9;
      end
      sum_ovf = c | ((DIGITS == 1) & bonus);
   end

   always_ff @(posedge clk) begin
      if (reset)
         score_bcd <= '0;
      else if (new_round)
         score_bcd <= '0;
      else if (score_en && (tick || bonus))
         score_bcd <= sum_ovf ? nines : sum_bcd;
   end

   // ---------------------------------------------------------------
   // Session high score, captured on the edge that enters OVER.
   // Packed BCD compares correctly as an unsigned binary vector.
   // ---------------------------------------------------------------
`ifdef SCORE_TRACKER_HIGHSCORE_EN
   logic end_round;

   assign end_round = gameover && ((state == S_RUN) || (state == S_PAUSE));

   always_ff @(posedge clk) begin
      if (reset) begin
         high_bcd <= '0;
         new_high <= 1'b0;
      end else if (new_round) begin
         new_high <= 1'b0;
      end else if (end_round && (score_bcd > high_bcd)) begin
         high_bcd <= score_bcd;
         new_high <= 1'b1;
      end
   end
`else
   assign high_bcd = '0;
   assign new_high = 1'b0;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker with DIGITS=2, TICK_DIV=4: directed vector table,
// hand-written corner sequences, then random stimulus against a reference model.

module tb_score_tracker;

   localparam int DIGITS   = 2;
   localparam int TICK_DIV = 4;
   localparam int MAXS     = 99;
`ifdef SCORE_TRACKER_HIGHSCORE_EN
   localparam bit HS_EN = 1'b1;
`else
   localparam bit HS_EN = 1'b0;
`endif

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVER = 3;

   logic clk = 1'b0;
   logic reset = 1'b0, start = 1'b0, pause = 1'b0, gameover = 1'b0, bonus = 1'b0;
   logic [4*DIGITS-1:0] score_bcd, high_bcd;
   logic running, over, new_high;

   score_tracker #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause),
      .gameover(gameover), .bonus(bonus), .score_bcd(score_bcd),
      .high_bcd(high_bcd), .running(running), .over(over), .new_high(new_high)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state: plain integers
   int m_state = M_IDLE;
   int m_score = 0;
   int m_high  = 0;
   int m_runcyc = 0;    // scoring cycles since round start
   bit m_nh    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic m_end_round();
      m_state = M_OVER;
      if (HS_EN && (m_score > m_high)) begin
         m_high = m_score;
         m_nh   = 1'b1;
      end
   endtask

   task automatic m_new_round();
      m_state  = M_RUN;
      m_score  = 0;
      m_runcyc = 0;
      m_nh     = 1'b0;
   endtask

   task automatic model_step();
      int add;
      if (reset === 1'b1) begin
         m_state = M_IDLE; m_score = 0; m_high = 0; m_runcyc = 0; m_nh = 1'b0;
      end else begin
         case (m_state)
            M_IDLE:  if (start === 1'b1) m_new_round();
            M_RUN: begin
               if (gameover === 1'b1)   m_end_round();
               else if (pause === 1'b1) m_state = M_PAUSE;
               else begin
                  add = 0;
                  m_runcyc++;
                  if (m_runcyc % TICK_DIV == 0) add += 1;
                  if (bonus === 1'b1) add += 10;
                  m_score = (m_score + add > MAXS) ? MAXS : m_score + add;
               end
            end
            M_PAUSE: begin
               if (gameover === 1'b1)    m_end_round();
               else if (pause !== 1'b1)  m_state = M_RUN;
            end
            default: if (start === 1'b1) m_new_round();
         endcase
      end
   endtask

   task automatic set_in(input bit r, input bit s, input bit p, input bit g, input bit b);
      reset = r; start = s; pause = p; gameover = g; bonus = b;
   endtask

   // one clock: advance model with the applied inputs, then compare all outputs
   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check(tag, {13'd0, score_bcd, high_bcd, running, over, new_high},
            {13'd0, to_bcd(m_score), to_bcd(m_high), 1'(m_state == M_RUN),
             1'(m_state == M_OVER), m_nh});
   endtask

   typedef struct {
      bit rst, st, ps, go, bn;
      logic [7:0] score;
      bit run, ovr;
   } vec_t;

   vec_t vq[$];

   task automatic addv(input bit r, input bit s, input bit p, input bit g, input bit b,
                       input logic [7:0] sc, input bit run, input bit ovr);
      vec_t v;
      v.rst = r; v.st = s; v.ps = p; v.go = g; v.bn = b;
      v.score = sc; v.run = run; v.ovr = ovr;
      vq.push_back(v);
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- directed table ----------------
      addv(1,0,0,0,0, 8'h00, 0, 0);                         // reset
      addv(0,0,0,1,1, 8'h00, 0, 0);                         // gameover/bonus ignored in IDLE
      addv(0,1,0,0,0, 8'h00, 1, 0);                         // start edge N
      repeat (3) addv(0,0,0,0,0, 8'h00, 1, 0);              // N+1..N+3
      addv(0,0,0,0,0, 8'h01, 1, 0);                         // first tick at N+4
      repeat (3) addv(0,0,0,0,0, 8'h01, 1, 0);
      addv(0,0,0,0,0, 8'h02, 1, 0);                         // N+8
      repeat (3) addv(0,0,0,0,0, 8'h02, 1, 0);
      addv(0,0,0,0,0, 8'h03, 1, 0);                         // N+12
      addv(0,0,0,0,1, 8'h13, 1, 0);                         // bonus
      repeat (2) addv(0,0,0,0,0, 8'h13, 1, 0);
      addv(0,0,0,0,0, 8'h14, 1, 0);                         // N+16 tick
      repeat (2) addv(0,0,0,0,0, 8'h14, 1, 0);              // phase now 2
      repeat (10) addv(0,0,1,0,0, 8'h14, 0, 0);             // paused
      addv(0,0,0,0,0, 8'h14, 1, 0);                         // resume edge, no advance
      addv(0,0,0,0,0, 8'h14, 1, 0);
      addv(0,0,0,0,0, 8'h15, 1, 0);                         // remainder of period

      foreach (vq[i]) begin
         set_in(vq[i].rst, vq[i].st, vq[i].ps, vq[i].go, vq[i].bn);
         cycle("vec_model");
         check("vec_score", score_bcd, vq[i].score);
         check("vec_state", {running, over}, {vq[i].run, vq[i].ovr});
      end

      // ---------------- BCD carry: 0x19 + bonus + tick ----------------
      set_in(1,0,0,0,0); cycle("carry_rst");
      set_in(0,1,0,0,0); cycle("carry_start");
      set_in(0,0,0,0,0);
      repeat (36) cycle("carry_run");
      check("carry_09", score_bcd, 8'h09);
      set_in(0,0,0,0,1); cycle("carry_b1");
      check("carry_19", score_bcd, 8'h19);
      set_in(0,0,0,0,0); repeat (2) cycle("carry_wait");
      set_in(0,0,0,0,1); cycle("carry_b2");
      check("carry_30", score_bcd, 8'h30);

      // ---------------- saturation ----------------
      repeat (6) cycle("sat_bonus");
      set_in(0,0,0,0,0);
      for (int k = 0; k < 100 && m_score != 97; k++) cycle("sat_run");
      check("sat_97", score_bcd, 8'h97);
      set_in(0,0,0,0,1); cycle("sat_b1");
      check("sat_99a", score_bcd, 8'h99);
      cycle("sat_b2");
      check("sat_99b", score_bcd, 8'h99);
      set_in(0,0,0,0,0); repeat (8) cycle("sat_hold");
      check("sat_hold", score_bcd, 8'h99);

      // ---------------- high score rounds ----------------
      set_in(1,0,0,0,0); cycle("hs_rst");
      set_in(0,1,0,0,0); cycle("hs_start1");
      set_in(0,0,0,0,0); repeat (20) cycle("hs_run1");
      check("hs_r1_score", score_bcd, 8'h05);
      set_in(0,0,0,1,0); cycle("hs_go1");
      check("hs_r1_end", {over, high_bcd, new_high}, {1'b1, HS_EN ? 8'h05 : 8'h00, HS_EN});
      repeat (2) cycle("hs_hold_over");
      check("hs_still_over", over, 1'b1);
      set_in(0,1,0,0,0); cycle("hs_start2");
      check("hs_r2_start", {running, score_bcd, new_high}, {1'b1, 8'h00, 1'b0});
      cycle("hs_start_held");
      set_in(0,0,0,0,0); repeat (14) cycle("hs_run2");
      check("hs_r2_score", score_bcd, 8'h03);
      set_in(0,0,0,1,0); cycle("hs_go2");          // coincides with a tick
      check("hs_r2_end", {over, score_bcd, high_bcd, new_high},
            {1'b1, 8'h03, HS_EN ? 8'h05 : 8'h00, 1'b0});
      // round 3: bonus ignored while paused, gameover from PAUSE
      set_in(0,1,0,0,0); cycle("hs_start3");
      set_in(0,0,0,0,1); cycle("hs_b3");
      set_in(0,0,1,0,0); cycle("hs_pause3");
      set_in(0,0,1,0,1); cycle("hs_pbonus3");
      check("hs_pause_bonus", score_bcd, 8'h10);
      set_in(0,0,1,1,0); cycle("hs_go3");
      check("hs_r3_end", {over, high_bcd, new_high},
            {1'b1, HS_EN ? 8'h10 : 8'h00, HS_EN});

      // ---------------- reset mid-round ----------------
      set_in(0,1,0,0,0); cycle("mr_start");
      set_in(0,0,0,0,0); repeat (5) cycle("mr_run");
      set_in(0,0,0,0,1); cycle("mr_bonus");
      set_in(1,0,0,0,0); cycle("mr_reset");
      check("mr_zero", {score_bcd, high_bcd, running, over, new_high}, 19'd0);
      set_in(0,0,0,0,0); cycle("mr_idle");
      check("mr_idle", {running, over}, 2'b00);

      // ---------------- randomized ----------------
      for (int n = 0; n < 3000; n++) begin
         set_in($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 12);
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
